// File: rtl/prog_loader_if.sv
// ============================================================================
// prog_loader_if
// ----------------------------------------------------------------------------
// Groups the signals between the program loader, its byte source, the
// instruction-memory write port and the processor control lines.
//   start        : begin a load
//   in_data      : program byte, MSB of each word first
//   in_valid     : in_data valid
//   in_ready     : loader accepts a byte (transfer = in_valid & in_ready)
//   mem_we       : instruction-memory write strobe, one cycle per word
//   mem_addr     : write address
//   mem_wdata    : write data
//   cpu_hold     : keeps the processor halted with PC cleared
//   cpu_start    : one-cycle release pulse
//   busy         : load in progress
//   done         : image loaded and verified
//   error        : bad length or checksum
//   words_loaded : data words written this load
// Modports: slave = loader side, master = source/system side.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
           busy, done, error, words_loaded
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
           busy, done, error, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
// ----------------------------------------------------------------------------
// Boot-time program loader. Accepts a byte stream (header word N, N data
// words, XOR checksum word; all big-endian), writes the data words to
// instruction memory from address 0, verifies the checksum and then releases
// the processor with a one-cycle start pulse.
// Ports:
//   clk1 : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : prog_loader_if.slave (stream, memory write port, cpu control)
// Revision: 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk1,
  input  logic                rst,
  prog_loader_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_t            state_q,        state_d;
  logic [1:0]        byte_cnt_q,     byte_cnt_d;
  logic [23:0]       shift_q,        shift_d;
  logic [ADDR_W:0]   n_words_q,      n_words_d;
  logic [31:0]       acc_q,          acc_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              mem_we_q,       mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
  logic [31:0]       mem_wdata_q,    mem_wdata_d;
  logic              cpu_hold_q,     cpu_hold_d;
  logic              cpu_start_q,    cpu_start_d;
  logic              done_q,         done_d;
  logic              error_q,        error_d;

  logic              in_ready;
  logic              xfer;
  logic              word_done;
  logic [31:0]       cur_word;
  logic [ADDR_W:0]   wl_next;

  // Ready (and busy) are pure functions of state so they drop in the very
  // cycle DONE/ERR is entered.
  assign in_ready  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CSUM);
  assign xfer      = bus.in_valid && in_ready;
  assign word_done = xfer && (byte_cnt_q == 2'd3);
  // Earlier three bytes sit in shift_q; the 4th byte completes the word.
  assign cur_word  = {shift_q, bus.in_data};
  assign wl_next   = words_loaded_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    n_words_d      = n_words_q;
    acc_d          = acc_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    cpu_start_d    = 1'b0;
    done_d         = done_q;
    error_d        = error_q;

    if (xfer) begin
      shift_d    = {shift_q[15:0], bus.in_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d        = S_HDR;
          byte_cnt_d     = 2'd0;
          shift_d        = '0;
          n_words_d      = '0;
          acc_d          = '0;
          words_loaded_d = '0;
          done_d         = 1'b0;
          error_d        = 1'b0;
          cpu_hold_d     = 1'b1;
        end
      end
      S_HDR: begin
        if (word_done) begin
          if ((cur_word == 32'd0) || (cur_word > MAX_WORDS_W)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            // Range check above guarantees N fits in ADDR_W+1 bits.
            n_words_d = cur_word[ADDR_W:0];
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_done) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_W-1:0];
          mem_wdata_d    = cur_word;
          words_loaded_d = wl_next;
          acc_d          = acc_q ^ cur_word;
          if (wl_next == n_words_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (word_done) begin
          if (cur_word == acc_q) begin
            state_d     = S_DONE;
            cpu_hold_d  = 1'b0;
            cpu_start_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 2'd0;
      shift_q        <= '0;
      n_words_q      <= '0;
      acc_q          <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      cpu_start_q    <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      n_words_q      <= n_words_d;
      acc_q          <= acc_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      cpu_start_q    <= cpu_start_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = in_ready;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.cpu_start    = cpu_start_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = words_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader
// ----------------------------------------------------------------------------
// Directed testbench for prog_loader: normal load, bad checksum, bad header
// lengths, stalled stream, mid-load reset, start during load and reload.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic clk1 = 1'b0;
  logic rst;

  always #5 clk1 = ~clk1;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Write/pulse monitor: only ever appended to here, read from the main block.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                start_pulses = 0;

  always @(negedge clk1) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.cpu_start === 1'b1) start_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk1);
      n++;
    end
    check("ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk1);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk1);
    bus.start = 1'b1;
    @(negedge clk1);
    bus.start = 1'b0;
    check({tag, "_busy"},     {63'd0, bus.busy},     64'd1);
    check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_hold"},     {63'd0, bus.cpu_hold}, 64'd1);
    check({tag, "_done"},     {63'd0, bus.done},     64'd0);
    check({tag, "_error"},    {63'd0, bus.error},    64'd0);
    check({tag, "_wl"},       64'(bus.words_loaded), 64'd0);
  endtask

  // Standard three-word image; csum selects good or bad checksum.
  task automatic load3(input logic [31:0] csum, input int maxgap);
    send_word(32'd3,        maxgap);
    send_word(32'h2801000a, maxgap);
    send_word(32'h28020014, maxgap);
    send_word(32'hfc000000, maxgap);
    send_word(csum,         maxgap);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_img3(input string tag, input int base);
    check({tag, "_nwr"}, 64'(wr_addr.size() - base), 64'd3);
    if (wr_addr.size() >= base + 3) begin
      check({tag, "_a0"}, 64'(wr_addr[base]),   64'd0);
      check({tag, "_d0"}, 64'(wr_data[base]),   64'h2801000a);
      check({tag, "_a1"}, 64'(wr_addr[base+1]), 64'd1);
      check({tag, "_d1"}, 64'(wr_data[base+1]), 64'h28020014);
      check({tag, "_a2"}, 64'(wr_addr[base+2]), 64'd2);
      check({tag, "_d2"}, 64'(wr_data[base+2]), 64'hfc000000);
    end
  endtask

  task automatic check_done(input string tag, input int wl, input int sp_base);
    @(negedge clk1);
    check({tag, "_cpu_start"}, {63'd0, bus.cpu_start}, 64'd1);
    check({tag, "_done"},      {63'd0, bus.done},      64'd1);
    check({tag, "_hold"},      {63'd0, bus.cpu_hold},  64'd0);
    check({tag, "_error"},     {63'd0, bus.error},     64'd0);
    check({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
    check({tag, "_busy"},      {63'd0, bus.busy},      64'd0);
    check({tag, "_wl"},        64'(bus.words_loaded),  64'(wl));
    @(negedge clk1);
    check({tag, "_start_low"}, {63'd0, bus.cpu_start}, 64'd0);
    check({tag, "_done_held"}, {63'd0, bus.done},      64'd1);
    check({tag, "_pulses"},    64'(start_pulses - sp_base), 64'd1);
  endtask

  task automatic check_err(input string tag, input int wl, input int sp_base);
    @(negedge clk1);
    check({tag, "_error"},     {63'd0, bus.error},     64'd1);
    check({tag, "_hold"},      {63'd0, bus.cpu_hold},  64'd1);
    check({tag, "_done"},      {63'd0, bus.done},      64'd0);
    check({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
    check({tag, "_busy"},      {63'd0, bus.busy},      64'd0);
    check({tag, "_wl"},        64'(bus.words_loaded),  64'(wl));
    @(negedge clk1);
    check({tag, "_err_held"},  {63'd0, bus.error},     64'd1);
    check({tag, "_pulses"},    64'(start_pulses - sp_base), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  {63'd0, bus.in_ready},  64'd0);
    check({tag, "_mem_we"},    {63'd0, bus.mem_we},    64'd0);
    check({tag, "_mem_addr"},  64'(bus.mem_addr),      64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata),     64'd0);
    check({tag, "_hold"},      {63'd0, bus.cpu_hold},  64'd1);
    check({tag, "_cpu_start"}, {63'd0, bus.cpu_start}, 64'd0);
    check({tag, "_busy"},      {63'd0, bus.busy},      64'd0);
    check({tag, "_done"},      {63'd0, bus.done},      64'd0);
    check({tag, "_error"},     {63'd0, bus.error},     64'd0);
    check({tag, "_wl"},        64'(bus.words_loaded),  64'd0);
  endtask

  initial begin
    int wb;
    int sp;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    check_reset_vals("rst");
    rst = 1'b0;

    // 1: good image, continuous stream
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s1_start");
    load3(32'hfc03001e, 0);
    check_done("s1", 3, sp);
    check_img3("s1", wb);

    // 2: bad checksum
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s2_start");
    load3(32'hfc03001f, 0);
    check_err("s2", 3, sp);
    check_img3("s2", wb);

    // 3a: zero-length header
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s3a_start");
    send_word(32'd0, 0);
    bus.in_valid = 1'b0;
    check_err("s3a", 0, sp);
    check("s3a_nwr", 64'(wr_addr.size() - wb), 64'd0);

    // 3b: header one above the limit
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s3b_start");
    send_word(32'(MAX_WORDS + 1), 0);
    bus.in_valid = 1'b0;
    check_err("s3b", 0, sp);
    check("s3b_nwr", 64'(wr_addr.size() - wb), 64'd0);

    // 4: same good image with random valid gaps
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s4_start");
    load3(32'hfc03001e, 5);
    check_done("s4", 3, sp);
    check_img3("s4", wb);

    // 5: reset after the 2nd data-word write, then a full reload
    wb = wr_addr.size();
    do_start("s5_start");
    send_word(32'd3, 0);
    send_word(32'h2801000a, 0);
    send_word(32'h28020014, 0);
    bus.in_valid = 1'b0;
    @(posedge clk1);
    #1;
    check("s5_nwr_pre", 64'(wr_addr.size() - wb), 64'd2);
    rst = 1'b1;
    #1;
    check_reset_vals("s5_async");
    @(negedge clk1);
    rst = 1'b0;
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s5b_start");
    load3(32'hfc03001e, 0);
    check_done("s5b", 3, sp);
    check_img3("s5b", wb);

    // 6: start pulsed during LOAD is ignored
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s6_start");
    send_word(32'd3, 0);
    send_word(32'h2801000a, 0);
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(posedge clk1);
    #1;
    bus.start = 1'b0;
    check("s6_busy_after_start", {63'd0, bus.busy}, 64'd1);
    check("s6_wl_after_start",   64'(bus.words_loaded), 64'd1);
    send_word(32'h28020014, 0);
    send_word(32'hfc000000, 0);
    send_word(32'hfc03001e, 0);
    bus.in_valid = 1'b0;
    check_done("s6", 3, sp);
    check_img3("s6", wb);

    // 6b: start after DONE, one-word image
    wb = wr_addr.size(); sp = start_pulses;
    do_start("s6b_start");
    send_word(32'd1, 0);
    send_word(32'hfc000000, 0);
    send_word(32'hfc000000, 0);
    bus.in_valid = 1'b0;
    check_done("s6b", 1, sp);
    check("s6b_nwr", 64'(wr_addr.size() - wb), 64'd1);
    if (wr_addr.size() > wb) begin
      check("s6b_a0", 64'(wr_addr[wb]), 64'd0);
      check("s6b_d0", 64'(wr_data[wb]), 64'hfc000000);
    end

    repeat (2) @(negedge clk1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the 32-bit pipelined processor. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them through the instruction-memory write port starting at address 0 and verifies an XOR checksum. It holds the processor halted until the image is good, then releases it with a one-cycle start pulse (PC=0).

## Interface
- ADDR_W, 10: instruction-memory address width.
- MAX_WORDS, 1024: largest accepted program length in words (must be ≤ 2^ADDR_W).

- clk1  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR.
- in_data  in  8  program byte, MSB of each word first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; transfer = in_valid & in_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- cpu_hold  out  1  keeps processor halted with PC cleared while high.
- cpu_start  out  1  one-cycle release pulse.
- busy  out  1  load in progress.
- done  out  1  image loaded and verified.
- error  out  1  bad length or checksum.
- words_loaded  out  ADDR_W+1  data words written this load.

## Operation
- Stream format: header word N (word count), then N data words, then checksum word = XOR of the N data words (header excluded). All words arrive as 4 bytes, MSB first.
- States: IDLE, HDR, LOAD, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start → HDR: clear byte counter, word count, checksum accumulator, done, error and words_loaded; set cpu_hold=1, busy=1.
- HDR: 4th byte completes N. N==0 or N>MAX_WORDS → ERR; otherwise latch N → LOAD.
- LOAD: each completed word → mem_we=1, mem_addr=words_loaded, mem_wdata=word; words_loaded+1; acc ^= word. Completing word N → CSUM.
- CSUM: completed word == acc → DONE (cpu_hold=0, cpu_start pulse, done=1); mismatch → ERR (error=1, cpu_hold stays 1).
- in_ready = 1 exactly in HDR, LOAD and CSUM.
- busy = 1 in HDR, LOAD and CSUM.
- start is ignored in HDR, LOAD and CSUM.
- Byte counter is 2 bits, wraps 3→0 on word completion; partial words persist across in_valid gaps indefinitely.
- Memory is never written outside LOAD; no write in HDR, CSUM or after an error.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, busy=0, done=0, error=0, words_loaded=0; state IDLE.
- start sampled in cycle t → state HDR and in_ready=1 in cycle t+1.
- mem_we/mem_addr/mem_wdata are registered: asserted in the cycle after the 4th-byte handshake, for exactly one cycle.
- Throughput: one byte per cycle with in_valid held high, so one word write every 4 cycles.
- Final checksum byte handshake at cycle t → state DONE/ERR at t+1. At t+1: cpu_start=1 (one cycle only), cpu_hold=0 and done=1 (held), or error=1 (held). in_ready=0 from t+1.
- Asynchronous rst mid-load aborts immediately to reset values. Words already written stay in memory; the processor remains held.
- words_loaded is stable after DONE/ERR until the next start.

## Test plan
- Load N=3, words 0x2801000a, 0x28020014, 0xfc000000, checksum 0xfc03001e, in_valid continuous → three writes at addr 0,1,2 with those data. Then one cpu_start pulse, cpu_hold=0, done=1, words_loaded=3, error=0.
- Same image with checksum 0xfc03001f → three writes, then error=1, cpu_hold=1, no cpu_start, done=0.
- Header N=0 → ERR after 4th header byte, no mem_we. Header N=MAX_WORDS+1 → same.
- Same image as scenario 1 with random 0–5 cycle in_valid gaps between bytes → identical writes and outcome; bytes not accepted while in_valid=0.
- Assert rst after the 2nd data-word write of scenario 1 → all outputs at reset values next cycle. A subsequent full load completes with done=1, words_loaded=3.
- Pulse start during LOAD → ignored, load proceeds unchanged. start after DONE → cpu_hold=1, done=0, busy=1; a second image (N=1, 0xfc000000, checksum 0xfc000000) writes addr 0 and completes.
